// File: rtl/warb_ctrl_if.sv
// Write-arbiter bundle: requester side (req/din), FIFO side (wfull/winc/wdata), status.
// Latency: none, this is wiring only.
// Backpressure: wfull comes from the FIFO and stalls the granted requester.
interface warb_if #(
    parameter int NREQ    = 4,
    parameter int DATA_WD = 8
);
    logic [NREQ-1:0]         req;
    logic [NREQ*DATA_WD-1:0] din;
    logic                    wfull;
    logic [NREQ-1:0]         gnt;
    logic                    winc;
    logic [DATA_WD-1:0]      wdata;
    logic                    wbusy;
    logic [3:0]              beat_cnt;

    // Arbiter side: owns the FIFO write port and the grant vector.
    modport master (
        input  req, din, wfull,
        output gnt, winc, wdata, wbusy, beat_cnt
    );

    // Requester / FIFO environment side.
    modport slave (
        output req, din, wfull,
        input  gnt, winc, wdata, wbusy, beat_cnt
    );
endinterface

// File: rtl/warb_ctrl.sv
// Round-robin arbiter giving NREQ requesters bursts on one FIFO write port (WARB_BURST_EN enables multi-beat bursts).
// Latency: grant 1 cycle after req from IDLE; winc/wdata combinational from the registered grant.
// Backpressure: wfull stalls the granted burst indefinitely with grant and beat count held.
module warb_ctrl #(
    parameter int NREQ      = 4,
    parameter int DATA_WD   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic   wclk,
    input  logic   wrst,
    warb_if.master bus
);

    localparam int IW = $clog2(NREQ);

`ifdef WARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    // Without bursts every beat is the last beat of its grant.
    localparam int         EFF_BURST = BURST_ON ? MAX_BURST : 1;
    localparam logic [3:0] LAST_BEAT = 4'(EFF_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
    logic [IW-1:0]       r_rr, w_rr_nxt;
    logic [3:0]          r_beat_cnt, w_beat_cnt_nxt;

    logic                w_hit;
    logic                w_beat;
    logic                w_release;
    logic [NREQ-1:0]     w_others;
    logic [NREQ-1:0]     w_cand;
    logic                w_pick_vld;
    logic [IW-1:0]       w_pick_idx;
    logic [IW-1:0]       w_probe;
    logic [NREQ-1:0]     w_pick_oh;
    logic [DATA_WD-1:0]  w_wdata;

    // Granted requester still asserting req; a beat also needs FIFO room and no reset.
    assign w_hit     = |(r_gnt & bus.req);
    assign w_beat    = (r_state == ST_GRANT) && w_hit && !bus.wfull && !wrst;
    assign w_release = (r_state == ST_GRANT) &&
                       (!w_hit || (w_beat && (r_beat_cnt == LAST_BEAT)));

    // Prefer anyone but the current grantee; fall back to the grantee if it is alone.
    assign w_others = bus.req & ~r_gnt;
    assign w_cand   = (|w_others) ? w_others : bus.req;

    // Round-robin search starting one past the last granted index.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_probe    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_probe = IW'((int'(r_rr) + 1 + k) % NREQ);
            if (!w_pick_vld && w_cand[w_probe]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_probe;
            end
        end
    end

    assign w_pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;

    // Steer the granted requester's data slice to the FIFO; zero when nobody holds a grant.
    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_wdata = bus.din[i*DATA_WD +: DATA_WD];
            end
        end
    end

    // Next-state logic: IDLE exit, beat counting, release and hand-over.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_rr_nxt       = r_rr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt    = ST_GRANT;
                    w_gnt_nxt      = w_pick_oh;
                    w_rr_nxt       = w_pick_idx;
                    w_beat_cnt_nxt = 4'd0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_beat_cnt_nxt = 4'd0;
                    if (w_pick_vld) begin
                        w_gnt_nxt = w_pick_oh;
                        w_rr_nxt  = w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_gnt_nxt      = '0;
                w_beat_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State register; reset parks the pointer on the last index so requester 0 wins first.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_rr       <= IW'(NREQ - 1);
            r_beat_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rr       <= w_rr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.winc     = w_beat;
    assign bus.wdata    = w_wdata;
    assign bus.wbusy    = (r_state == ST_GRANT);
    assign bus.beat_cnt = BURST_ON ? r_beat_cnt : 4'd0;

endmodule

// File: tb/tb_warb_ctrl.sv
// Bench for warb_ctrl: directed scenarios with literal expectations plus randomized traffic.
// A cycle-level model predicts every output each cycle from the arbitration rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_warb_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;

`ifdef WARB_BURST_EN
    localparam bit TB_BURST = 1'b1;
`else
    localparam bit TB_BURST = 1'b0;
`endif
    localparam int TB_EFF = TB_BURST ? MB : 1;

    logic wclk = 1'b0;
    logic wrst = 1'b1;

    int errors = 0;
    int checks = 0;

    warb_if #(.NREQ(NREQ), .DATA_WD(DW)) bus ();

    warb_ctrl #(.NREQ(NREQ), .DATA_WD(DW), .MAX_BURST(MB)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_own   = -1;   // granted requester index, -1 when idle
    int m_rr    = NREQ - 1;
    int m_cnt   = 0;
    bit m_valid = 1'b0;

    function automatic int pick(input logic [NREQ-1:0] mask, input int rr);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (rr + k) % NREQ;
            if (mask[j]) return j;
        end
        return -1;
    endfunction

    // Compare DUT against the model, then advance the model with this cycle's inputs.
    always @(negedge wclk) begin
        logic [NREQ-1:0] e_gnt;
        logic [DW-1:0]   e_wdata;
        logic            e_winc;
        logic [NREQ-1:0] others;
        int              nxt;
        bit              rel;
        if (m_valid) begin
            e_gnt   = (m_own < 0) ? '0 : (NREQ'(1) << m_own);
            e_wdata = (m_own < 0) ? '0 : bus.din[m_own*DW +: DW];
            e_winc  = !wrst && (m_own >= 0) && bus.req[(m_own < 0) ? 0 : m_own] && !bus.wfull;
            chk("model_gnt",      32'(bus.gnt),      32'(e_gnt));
            chk("model_winc",     32'(bus.winc),     32'(e_winc));
            chk("model_wdata",    32'(bus.wdata),    32'(e_wdata));
            chk("model_wbusy",    32'(bus.wbusy),    32'(m_own >= 0));
            chk("model_beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
        end
        if (wrst) begin
            m_own = -1; m_rr = NREQ - 1; m_cnt = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_own < 0) begin
                nxt = pick(bus.req, m_rr);
                if (nxt >= 0) begin m_own = nxt; m_rr = nxt; m_cnt = 0; end
            end else begin
                rel = 1'b0;
                if (!bus.req[m_own]) rel = 1'b1;
                else if (!bus.wfull) begin
                    m_cnt++;
                    if (m_cnt >= TB_EFF) rel = 1'b1;
                end
                if (rel) begin
                    others = bus.req & ~(NREQ'(1) << m_own);
                    nxt = pick(others, m_rr);
                    if (nxt < 0 && bus.req[m_own]) nxt = m_own;
                    m_own = nxt;
                    if (nxt >= 0) m_rr = nxt;
                    m_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        wrst      = 1'b1;
        bus.req   = '0;
        bus.wfull = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        bus.req   = '0;
        bus.wfull = 1'b0;
        bus.din   = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;

        // Sole requester 0: first grant, burst, re-grant to itself.
        do_reset();
        bus.req = 4'b0001;
        for (int c = 0; c <= 6; c++) begin
            @(negedge wclk);
            if (c == 0) begin
                chk("reset_gnt",   32'(bus.gnt),   32'h0);
                chk("reset_winc",  32'(bus.winc),  32'h0);
                chk("reset_wbusy", 32'(bus.wbusy), 32'h0);
                chk("reset_wdata", 32'(bus.wdata), 32'h0);
                chk("reset_cnt",   32'(bus.beat_cnt), 32'h0);
            end
            if (c == 1) begin
                chk("sole_first_gnt", 32'(bus.gnt),   32'h1);
                chk("sole_wdata",     32'(bus.wdata), 32'h11);
            end
            if (c >= 1 && c <= 4) begin
                chk("sole_winc", 32'(bus.winc),     32'h1);
                chk("sole_cnt",  32'(bus.beat_cnt), TB_BURST ? 32'(c - 1) : 32'h0);
            end
            if (c == 5) begin
                chk("sole_regrant_gnt", 32'(bus.gnt),      32'h1);
                chk("sole_regrant_cnt", 32'(bus.beat_cnt), 32'h0);
            end
            next_cyc();
        end

        // All requesting: round-robin order, continuous writes.
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c <= 17; c++) begin
            @(negedge wclk);
            if (c >= 1) begin
                chk("rr_gnt",  32'(bus.gnt),
                    32'(1) << (((c - 1) / TB_EFF) % NREQ));
                chk("rr_winc", 32'(bus.winc), 32'h1);
            end
            next_cyc();
        end

        // FIFO full stall in the middle of a burst.
        do_reset();
        bus.req = 4'b0001;
        for (int c = 0; c <= 10; c++) begin
            bus.wfull = (c >= 3 && c <= 7);
            @(negedge wclk);
            if (c >= 3 && c <= 7) begin
                chk("stall_winc", 32'(bus.winc),     32'h0);
                chk("stall_gnt",  32'(bus.gnt),      32'h1);
                chk("stall_cnt",  32'(bus.beat_cnt), TB_BURST ? 32'h2 : 32'h0);
            end
            if (c == 8) chk("resume_cnt8", 32'(bus.beat_cnt), TB_BURST ? 32'h2 : 32'h0);
            if (c == 9) chk("resume_cnt9", 32'(bus.beat_cnt), TB_BURST ? 32'h3 : 32'h0);
            if (c == 8 || c == 9) chk("resume_winc", 32'(bus.winc), 32'h1);
            if (c == 10) chk("after_stall_cnt", 32'(bus.beat_cnt), 32'h0);
            next_cyc();
        end
        bus.wfull = 1'b0;

        // Requester 0 drops after one beat; requester 2 takes over.
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            bus.req = (c >= 2) ? 4'b0100 : 4'b0101;
            @(negedge wclk);
            if (c == 1) chk("drop_first_gnt", 32'(bus.gnt), 32'h1);
            if (c == 2) begin
                chk("drop_gnt2",  32'(bus.gnt),  TB_BURST ? 32'h1 : 32'h4);
                chk("drop_winc2", 32'(bus.winc), TB_BURST ? 32'h0 : 32'h1);
            end
            if (c == 3) begin
                chk("drop_gnt3",   32'(bus.gnt),      32'h4);
                chk("drop_cnt3",   32'(bus.beat_cnt), 32'h0);
                chk("drop_wdata3", 32'(bus.wdata),    32'h33);
            end
            next_cyc();
        end

        // Reset pulsed mid-burst.
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c <= 6; c++) begin
            wrst = (c == 3);
            @(negedge wclk);
            if (c == 3) begin
                chk("midrst_cnt",  32'(bus.beat_cnt), TB_BURST ? 32'h2 : 32'h0);
                chk("midrst_winc", 32'(bus.winc),     32'h0);
            end
            if (c == 4) begin
                chk("postrst_gnt",  32'(bus.gnt),  32'h0);
                chk("postrst_winc", 32'(bus.winc), 32'h0);
            end
            if (c == 5) chk("postrst_regrant", 32'(bus.gnt), 32'h1);
            next_cyc();
        end
        wrst = 1'b0;

        // Randomized traffic: sticky requests, random backpressure, rare resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(3, 0) == 0) bus.req = NREQ'($urandom);
            bus.wfull = ($urandom_range(3, 0) == 0);
            bus.din   = $urandom;
            wrst      = ($urandom_range(299, 0) == 0);
            next_cyc();
        end
        wrst = 1'b0;
        bus.req = '0;
        repeat (3) next_cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
